// File: rtl/conv_encoder_param_if.sv
// Handshake, config and status bundle for conv_encoder_param.
// master = bit source / sink side (testbench or host), slave = encoder.
interface conv_encoder_param_if #(
  parameter int MAX_K  = 9,
  parameter int MAX_N  = 3,
  parameter int FLEN_W = 12
) ();
  logic                   i_start;
  logic [1:0]             i_code_rate;
  logic [3:0]             i_constr_len;
  logic [MAX_N*MAX_K-1:0] i_gen_poly;
  logic                   i_term_mode;
  logic [FLEN_W-1:0]      i_frame_len;
  logic                   i_valid;
  logic                   i_bit;
  logic                   o_ready;
  logic                   o_valid;
  logic [MAX_N-1:0]       o_data;
  logic                   i_ready;
  logic                   o_last;
  logic                   o_busy;
  logic                   o_cfg_err;

  modport slave (
    input  i_start, i_code_rate, i_constr_len, i_gen_poly, i_term_mode, i_frame_len,
    input  i_valid, i_bit, i_ready,
    output o_ready, o_valid, o_data, o_last, o_busy, o_cfg_err
  );

  modport master (
    output i_start, i_code_rate, i_constr_len, i_gen_poly, i_term_mode, i_frame_len,
    output i_valid, i_bit, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_busy, o_cfg_err
  );
endinterface

// File: rtl/conv_encoder_param.sv
// Runtime-configurable feedforward convolutional encoder (K=3..MAX_K, rate 1/2 or 1/3)
// with frame-length control, optional zero-tail flush and a one-entry output register.
module conv_encoder_param #(
  parameter int MAX_K  = 9,
  parameter int MAX_N  = 3,
  parameter int FLEN_W = 12
) (
  input logic                  clk,
  input logic                  rst,
  conv_encoder_param_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TAIL, S_DRAIN} state_t;

  state_t                 state_q;
  logic [MAX_K-2:0]       sr_q;
  logic [3:0]             k_q;
  logic [1:0]             rate_q;
  logic [MAX_N*MAX_K-1:0] poly_q;
  logic                   term_q;
  logic [FLEN_W-1:0]      flen_q;
  logic [FLEN_W-1:0]      info_cnt_q;
  logic [3:0]             tail_cnt_q;
  logic                   o_valid_q;
  logic                   o_last_q;
  logic [MAX_N-1:0]       o_data_q;
  logic                   cfg_err_q;

  logic                   slot_free;
  logic                   accept;
  logic                   tail_go;
  logic                   load;
  logic                   in_bit;
  logic                   start_go;
  logic                   cfg_ok;
  logic                   info_done;
  logic                   tail_done;
  logic                   last_d;
  logic [MAX_K-1:0]       win;
  logic [MAX_K-1:0]       kmask;
  logic [MAX_N-1:0]       o_data_d;

  // Handshake qualifiers: a new word may enter when the output slot is empty or being drained.
  assign slot_free = !o_valid_q | bus.i_ready;
  assign accept    = (state_q == S_RUN) & slot_free & bus.i_valid;
  assign tail_go   = (state_q == S_TAIL) & slot_free;
  assign load      = accept | tail_go;
  // Tail cycles push a zero through the same datapath as an info bit.
  assign in_bit    = accept & bus.i_bit;
  assign win       = {sr_q, in_bit};
  assign start_go  = (state_q == S_IDLE) & bus.i_start;
  assign info_done = (info_cnt_q == flen_q - FLEN_W'(1));
  assign tail_done = (tail_cnt_q == k_q - 4'd2);
  assign last_d    = accept ? (info_done & !term_q) : tail_done;

  // Config legality at i_start: rate 2/3 within MAX_N, K in 3..MAX_K, non-empty frame.
  assign cfg_ok = ((bus.i_code_rate == 2'd2) | (bus.i_code_rate == 2'd3))
                & (32'(bus.i_code_rate) <= MAX_N)
                & (bus.i_constr_len >= 4'd3)
                & (32'(bus.i_constr_len) <= MAX_K)
                & (bus.i_frame_len != '0);

  // Code word for the current window; taps at delays >= K and polys >= rate contribute nothing.
  always_comb begin
    kmask    = '0;
    o_data_d = '0;
    for (int m = 0; m < MAX_K; m++) kmask[m] = (m < 32'(k_q));
    for (int j = 0; j < MAX_N; j++)
      if (j < 32'(rate_q)) o_data_d[j] = ^(win & kmask & poly_q[j*MAX_K +: MAX_K]);
  end

  // Control FSM plus output register, shift register and frame counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      k_q        <= '0;
      rate_q     <= '0;
      poly_q     <= '0;
      term_q     <= 1'b0;
      flen_q     <= '0;
      info_cnt_q <= '0;
      tail_cnt_q <= '0;
      o_valid_q  <= 1'b0;
      o_last_q   <= 1'b0;
      o_data_q   <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= start_go & !cfg_ok;

      if (load) begin
        o_valid_q <= 1'b1;
        o_data_q  <= o_data_d;
        o_last_q  <= last_d;
        sr_q      <= {sr_q[MAX_K-3:0], in_bit};
      end else if (bus.i_ready) begin
        o_valid_q <= 1'b0;
        o_last_q  <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start_go && cfg_ok) begin
            k_q        <= bus.i_constr_len;
            rate_q     <= bus.i_code_rate;
            poly_q     <= bus.i_gen_poly;
            term_q     <= bus.i_term_mode;
            flen_q     <= bus.i_frame_len;
            info_cnt_q <= '0;
            tail_cnt_q <= '0;
            sr_q       <= '0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            info_cnt_q <= info_cnt_q + FLEN_W'(1);
            if (info_done) state_q <= term_q ? S_TAIL : S_DRAIN;
          end
        end
        S_TAIL: begin
          if (tail_go) begin
            if (tail_done) state_q <= S_DRAIN;
            else           tail_cnt_q <= tail_cnt_q + 4'd1;
          end
        end
        S_DRAIN: begin
          if (o_valid_q && bus.i_ready && o_last_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready   = (state_q == S_RUN) & slot_free;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_data    = o_data_q;
  assign bus.o_last    = o_last_q;
  assign bus.o_busy    = (state_q != S_IDLE);
  assign bus.o_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_conv_encoder_param.sv
// Scoreboard bench for conv_encoder_param: expected words are queued at stimulus time
// from a direct convolution model; a negedge monitor pops and compares on each handshake.
module tb_conv_encoder_param;
  localparam int MAX_K  = 9;
  localparam int MAX_N  = 3;
  localparam int FLEN_W = 12;
  localparam int PW     = MAX_N*MAX_K;

  typedef struct packed {
    logic [MAX_N-1:0] data;
    logic             last;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_encoder_param_if #(.MAX_K(MAX_K), .MAX_N(MAX_N), .FLEN_W(FLEN_W)) ifc ();
  conv_encoder_param #(.MAX_K(MAX_K), .MAX_N(MAX_N), .FLEN_W(FLEN_W)) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  int    total = 0;
  int    bad   = 0;
  word_t exp_q[$];
  int    words_seen = 0;
  bit    mon_en = 0;
  bit    hold_v = 0;
  word_t held;
  word_t mon_e;

  task automatic chk(string nm, int act, int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Monitor: pop/compare on every accepted word, and check stalled words stay put.
  always @(negedge clk) begin
    if (rst && mon_en) begin
      if (ifc.o_valid) begin
        if (hold_v) begin
          chk("hold_data", int'(ifc.o_data), int'(held.data));
          chk("hold_last", int'(ifc.o_last), int'(held.last));
        end
        if (ifc.i_ready) begin
          if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
          else begin
            mon_e = exp_q.pop_front();
            chk("data", int'(ifc.o_data), int'(mon_e.data));
            chk("last", int'(ifc.o_last), int'(mon_e.last));
          end
          words_seen++;
          hold_v = 0;
        end else begin
          hold_v = 1;
          held   = '{ifc.o_data, ifc.o_last};
          chk("o_ready_when_full", int'(ifc.o_ready), 0);
        end
      end else hold_v = 0;
    end else hold_v = 0;
  end

  // Reference: c_j[t] = XOR over m<K of g_j[m] & u[t-m]; u zero before 0 and after n (tail).
  task automatic model(int k, int rate, logic [PW-1:0] polys, bit term, bit bits[$]);
    int n, tot;
    word_t w;
    n   = bits.size();
    tot = n + (term ? k-1 : 0);
    for (int t = 0; t < tot; t++) begin
      w = '0;
      for (int j = 0; j < rate; j++) begin
        bit p = 0;
        for (int m = 0; m < k; m++)
          if (t-m >= 0 && t-m < n && polys[j*MAX_K+m]) p ^= bits[t-m];
        w.data[j] = p;
      end
      w.last = (t == tot-1);
      exp_q.push_back(w);
    end
  endtask

  task automatic push_w(int d, bit l);
    word_t w;
    w.data = MAX_N'(d);
    w.last = l;
    exp_q.push_back(w);
  endtask

  task automatic set_ready(int rmode, inout bit tog);
    case (rmode)
      0:       ifc.i_ready = 1'b1;
      1:       begin ifc.i_ready = tog; tog = ~tog; end
      default: ifc.i_ready = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  // Start a frame and feed its bits; abort_at >= 0 returns early once that many bits went in.
  task automatic drive_frame(int k, int rate, logic [PW-1:0] polys, bit term, bit bits[$],
                             int rmode, int abort_at);
    int n, idx, cyc;
    bit acc, tog;
    n = bits.size(); idx = 0; cyc = 0; tog = 1;
    words_seen = 0;
    ifc.i_ready      = 1'b1;
    ifc.i_code_rate  = 2'(rate);
    ifc.i_constr_len = 4'(k);
    ifc.i_gen_poly   = polys;
    ifc.i_term_mode  = term;
    ifc.i_frame_len  = FLEN_W'(n);
    ifc.i_start      = 1'b1;
    @(posedge clk); #1;
    ifc.i_start = 1'b0;
    chk("busy_after_start", int'(ifc.o_busy), 1);
    while (idx < n && cyc < 2000) begin
      if (abort_at >= 0 && idx == abort_at) break;
      ifc.i_valid = ($urandom_range(0, 3) != 0);
      ifc.i_bit   = bits[idx];
      set_ready(rmode, tog);
      @(negedge clk);
      acc = ifc.i_valid && ifc.o_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    ifc.i_valid = 1'b0;
    if (abort_at >= 0) return;
    while (ifc.o_busy && cyc < 4000) begin
      set_ready(rmode, tog);
      @(posedge clk); #1;
      cyc++;
    end
    chk("frame_finished", int'(ifc.o_busy), 0);
    chk("words_left", exp_q.size(), 0);
    chk("word_count", words_seen, n + (term ? k-1 : 0));
    exp_q.delete();
  endtask

  task automatic cfg_bad(int k, int rate, int flen);
    ifc.i_code_rate  = 2'(rate);
    ifc.i_constr_len = 4'(k);
    ifc.i_frame_len  = FLEN_W'(flen);
    ifc.i_term_mode  = 1'b1;
    ifc.i_start      = 1'b1;
    @(posedge clk); #1;
    ifc.i_start = 1'b0;
    chk("cfg_err_pulse", int'(ifc.o_cfg_err), 1);
    chk("cfg_err_busy", int'(ifc.o_busy), 0);
    chk("cfg_err_valid", int'(ifc.o_valid), 0);
    @(posedge clk); #1;
    chk("cfg_err_clears", int'(ifc.o_cfg_err), 0);
    chk("cfg_err_idle", int'(ifc.o_busy), 0);
  endtask

  task automatic push_s1();
    push_w(3'b011, 0); push_w(3'b001, 0); push_w(3'b000, 0);
    push_w(3'b010, 0); push_w(3'b010, 0); push_w(3'b011, 1);
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, "_valid"}, int'(ifc.o_valid), 0);
    chk({tag, "_ready"}, int'(ifc.o_ready), 0);
    chk({tag, "_busy"},  int'(ifc.o_busy), 0);
    chk({tag, "_last"},  int'(ifc.o_last), 0);
    chk({tag, "_data"},  int'(ifc.o_data), 0);
    chk({tag, "_err"},   int'(ifc.o_cfg_err), 0);
  endtask

  logic [PW-1:0] p1, p3, pr;
  bit            b[$];

  initial begin
    ifc.i_start = 0; ifc.i_code_rate = 0; ifc.i_constr_len = 0; ifc.i_gen_poly = '0;
    ifc.i_term_mode = 0; ifc.i_frame_len = '0; ifc.i_valid = 0; ifc.i_bit = 0; ifc.i_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst    = 1'b1;
    mon_en = 1;

    // g0=111, g1=101 with junk above bit K-1 that must be masked off
    p1 = '0;
    p1[8:0]  = 9'b101101_111;
    p1[17:9] = 9'b011010_101;
    p1[26:18] = 9'b111111_111;
    b = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Zero-tail: 11,10,00,01,01,11 (g0 g1)
    push_s1();
    drive_frame(3, 2, p1, 1'b1, b, 0, -1);

    // Truncated: 11,10,00,01
    push_w(3'b011, 0); push_w(3'b001, 0); push_w(3'b000, 0); push_w(3'b010, 1);
    drive_frame(3, 2, p1, 1'b0, b, 0, -1);

    // K=9 rate 1/3, polys 557/663/711 octal, 12 random bits -> 20 words
    p3 = {9'o711, 9'o663, 9'o557};
    b.delete();
    for (int i = 0; i < 12; i++) b.push_back(bit'($urandom_range(0, 1)));
    model(9, 3, p3, 1'b1, b);
    drive_frame(9, 3, p3, 1'b1, b, 0, -1);

    // Alternating i_ready backpressure
    pr = PW'({$urandom(), $urandom()});
    b.delete();
    for (int i = 0; i < 16; i++) b.push_back(bit'($urandom_range(0, 1)));
    model(5, 2, pr, 1'b1, b);
    drive_frame(5, 2, pr, 1'b1, b, 1, -1);

    // Illegal configs
    cfg_bad(2, 2, 4);
    cfg_bad(3, 1, 4);
    cfg_bad(3, 2, 0);
    cfg_bad(10, 3, 4);

    // Reset while flushing the tail, then the same frame from a clean state
    b = '{1'b1, 1'b0, 1'b1, 1'b1};
    push_s1();
    drive_frame(3, 2, p1, 1'b1, b, 0, 4);
    chk("busy_before_abort", int'(ifc.o_busy), 1);
    mon_en = 0;
    rst    = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_idle_outputs("abort");
    @(posedge clk); #1;
    rst    = 1'b1;
    mon_en = 1;
    push_s1();
    drive_frame(3, 2, p1, 1'b1, b, 0, -1);

    // Random frames across the config space
    for (int f = 0; f < 10; f++) begin
      int  k, rate, n;
      bit  term;
      k    = $urandom_range(3, MAX_K);
      rate = $urandom_range(2, 3);
      n    = $urandom_range(1, 24);
      term = bit'($urandom_range(0, 1));
      pr   = PW'({$urandom(), $urandom()});
      b.delete();
      for (int i = 0; i < n; i++) b.push_back(bit'($urandom_range(0, 1)));
      model(k, rate, pr, term, b);
      drive_frame(k, rate, pr, term, b, $urandom_range(0, 2), -1);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
